// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures memory read data into IF/ID,
// with stall, branch redirect plus one-cycle flush, boot bubble and saturating fetch count.
module fetch_stage #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned INSTR_W  = 20,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [ADDR_W-1:0]  pc_addr,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               if_id_valid,
   output logic [CNT_W-1:0]   fetch_count
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Next-state: branch beats stall in RUN; FLUSH accepts re-redirects but ignores stall.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_BOOT: begin
            valid_d = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
               state_d = S_FLUSH;
            end else if (!stall) begin
               instr_d = instr_in;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + ADDR_W'(1);
               cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         S_FLUSH: begin
            valid_d = 1'b0;
            if (branch_taken) begin
               pc_d = branch_target;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_BOOT;
         pc_q    <= ADDR_W'(RESET_PC);
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_addr     = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc    = ipc_q;
   assign if_id_valid = valid_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/branch/memory-write traffic,
// checked against a bubble-counting reference model. A second instance uses a 4-bit counter.
module tb_fetch_stage;

   logic        Clock;
   logic        Resetn;
   logic        stall;
   logic        branch_taken;
   logic [4:0]  branch_target;
   logic [19:0] mem [32];

   logic [19:0] instr_in, instr_in4;
   logic [4:0]  pc_addr, pc_addr4;
   logic [19:0] if_id_instr, if_id_instr4;
   logic [4:0]  if_id_pc, if_id_pc4;
   logic        if_id_valid, if_id_valid4;
   logic [15:0] fetch_count;
   logic [3:0]  fetch_count4;

   int checks = 0;
   int failures = 0;

   // reference model
   int m_pc, m_ipc, m_n;
   logic [19:0] m_instr;
   logic m_valid, m_boot, m_flush;
   logic r_s, r_b;
   logic [4:0] r_t;

   assign instr_in  = mem[pc_addr];
   assign instr_in4 = mem[pc_addr4];

   fetch_stage dut (
      .Clock(Clock), .Resetn(Resetn), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr_in(instr_in), .pc_addr(pc_addr),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
      .fetch_count(fetch_count)
   );

   fetch_stage #(.CNT_W(4)) dut_c4 (
      .Clock(Clock), .Resetn(Resetn), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .instr_in(instr_in4), .pc_addr(pc_addr4),
      .if_id_instr(if_id_instr4), .if_id_pc(if_id_pc4), .if_id_valid(if_id_valid4),
      .fetch_count(fetch_count4)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ipc = 0; m_n = 0; m_instr = '0;
      m_valid = 1'b0; m_boot = 1'b1; m_flush = 1'b0;
   endtask

   // One clock of the fetch rules: a boot bubble, then redirects cost one dead cycle.
   task automatic model_step(input logic s, input logic b, input int tgt);
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_flush) begin
         if (b) m_pc = tgt;
         else   m_flush = 1'b0;
      end else if (b) begin
         m_pc = tgt; m_valid = 1'b0; m_flush = 1'b1;
      end else if (!s) begin
         m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
         m_pc = (m_pc + 1) % 32; m_n++;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc_addr"}, 32'(pc_addr), 32'(m_pc));
      chk({tag, ".instr"},   32'(if_id_instr), 32'(m_instr));
      chk({tag, ".if_pc"},   32'(if_id_pc), 32'(m_ipc));
      chk({tag, ".valid"},   32'(if_id_valid), 32'(m_valid));
      chk({tag, ".count"},   32'(fetch_count), 32'((m_n > 65535) ? 65535 : m_n));
      chk({tag, ".count4"},  32'(fetch_count4), 32'((m_n > 15) ? 15 : m_n));
      chk({tag, ".pc4"},     32'(pc_addr4), 32'(m_pc));
   endtask

   task automatic step(input logic s, input logic b, input logic [4:0] tgt, input string tag);
      stall = s; branch_taken = b; branch_target = tgt;
      @(posedge Clock);
      model_step(s, b, int'(tgt));
      #1;
      check_all(tag);
   endtask

   task automatic run_random(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge Clock);
            mem[$urandom_range(0, 31)] = 20'($urandom);
         end
         r_s = ($urandom_range(0, 3) == 0);
         r_b = ($urandom_range(0, 9) == 0);
         r_t = 5'($urandom);
         step(r_s, r_b, r_t, tag);
      end
   endtask

   initial begin
      Resetn = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      for (int i = 0; i < 32; i++) mem[i] = 20'($urandom);
      mem[0] = 20'hF001C;
      mem[1] = 20'hF101E;
      model_reset();
      repeat (2) @(posedge Clock);
      #1;
      check_all("reset");

      // boot bubble then first two fetches
      @(negedge Clock);
      Resetn = 1'b1;
      step(1'b0, 1'b1, 5'd9, "boot");
      chk("boot.valid_lit", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 5'd0, "fetch0");
      chk("fetch0.instr_lit", 32'(if_id_instr), 32'hF001C);
      chk("fetch0.pc_lit", 32'(pc_addr), 32'd1);
      step(1'b0, 1'b0, 5'd0, "fetch1");
      chk("fetch1.instr_lit", 32'(if_id_instr), 32'hF101E);
      chk("fetch1.count_lit", 32'(fetch_count), 32'd2);

      // stall at pc=5
      repeat (3) step(1'b0, 1'b0, 5'd0, "to5");
      repeat (3) step(1'b1, 1'b0, 5'd0, "stall");
      chk("stall.pc_lit", 32'(pc_addr), 32'd5);
      step(1'b0, 1'b0, 5'd0, "unstall");
      chk("unstall.pc_lit", 32'(if_id_pc), 32'd5);

      // branch with simultaneous stall at pc=7
      step(1'b0, 1'b0, 5'd0, "to7");
      step(1'b1, 1'b1, 5'd2, "brstall");
      chk("brstall.pc_lit", 32'(pc_addr), 32'd2);
      step(1'b0, 1'b0, 5'd0, "flush");
      chk("flush.valid_lit", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 5'd0, "afterbr");
      chk("afterbr.pc_lit", 32'(if_id_pc), 32'd2);

      // wrap-around from 30
      step(1'b0, 1'b1, 5'd30, "br30");
      step(1'b0, 1'b0, 5'd0, "fl30");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 5'd0, "wrap");
      chk("wrap.pc_lit", 32'(pc_addr), 32'd2);

      // falling-edge write to the current pc is what gets captured
      @(negedge Clock);
      mem[m_pc] = 20'hA5A5A;
      step(1'b0, 1'b0, 5'd0, "negwr");
      chk("negwr.instr_lit", 32'(if_id_instr), 32'hA5A5A);

      // re-redirect during flush, stall ignored during flush
      step(1'b0, 1'b1, 5'd10, "br10");
      step(1'b0, 1'b1, 5'd12, "br12");
      step(1'b1, 1'b0, 5'd0, "flstall");
      step(1'b0, 1'b0, 5'd0, "at12");
      chk("at12.pc_lit", 32'(if_id_pc), 32'd12);

      run_random(300, "rand1");

      // async reset between edges at pc=12
      step(1'b0, 1'b1, 5'd12, "brr12");
      step(1'b0, 1'b0, 5'd0, "flr12");
      #2;
      Resetn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge Clock);
      Resetn = 1'b1;
      step(1'b0, 1'b0, 5'd0, "reboot");
      chk("reboot.valid_lit", 32'(if_id_valid), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 5'd0, "sat");
      chk("sat.count4_lit", 32'(fetch_count4), 32'd15);

      run_random(300, "rand2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
